// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared types and default constants for the timer scheduler.
// Holds the per-channel state encoding used by timer_channel and the default
// parameter values used by timer_sched.
package timer_sched_pkg;

   // Channel state: IDLE waits for a start, RUN counts base ticks down.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ch_state_t;

   // 50 MHz / 50000 gives a 1 kHz base tick.
   localparam int PRESCALE_DEF = 50000;
   localparam int CNT_W_DEF    = 16;
   localparam int NUM_CH_DEF   = 4;

endpackage : timer_sched_pkg

// File: rtl/timer_channel.sv
// timer_channel: one countdown channel of the timer scheduler.
// Loads a duration on start, decrements on each shared base tick and pulses
// o_done one cycle after the tick that exhausts the count. Cancel aborts
// silently. A zero duration produces an immediate done without going busy.
// Priority: cancel > start > tick.
module timer_channel
   import timer_sched_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic             clk_in,
   input  logic             rst,
   input  logic             i_tick,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_dur,
   input  logic             i_cancel,
   output logic             o_busy,
   output logic             o_done
);

   ch_state_t        r_state;
   ch_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_remaining;
   logic [CNT_W-1:0] w_remaining_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             w_dur_zero;
   logic             w_last_tick;

   assign w_dur_zero  = (i_dur == '0);
   // Expire at 1 (never decrement below 1), so remaining can never underflow.
   assign w_last_tick = (r_remaining <= CNT_W'(1));

   // State, count and done pulse registers; async reset drops any run silently.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         r_done      <= w_done_nxt;
      end
   end

   // Next-state logic: cancel first, then start (reload), then tick countdown.
   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      w_done_nxt      = 1'b0;
      if (i_cancel) begin
         w_state_nxt     = ST_IDLE;
         w_remaining_nxt = '0;
      end else if (i_start) begin
         if (w_dur_zero) begin
            // Zero-length request completes at once and never shows busy.
            w_state_nxt     = ST_IDLE;
            w_remaining_nxt = '0;
            w_done_nxt      = 1'b1;
         end else begin
            // A start while running discards the old count; no done for it.
            w_state_nxt     = ST_RUN;
            w_remaining_nxt = i_dur;
         end
      end else if ((r_state == ST_RUN) && i_tick) begin
         if (w_last_tick) begin
            w_state_nxt     = ST_IDLE;
            w_remaining_nxt = '0;
            w_done_nxt      = 1'b1;
         end else begin
            w_remaining_nxt = r_remaining - 1'b1;
         end
      end
   end

   // RUN encodes as 1, so busy is the state flop itself.
   assign o_busy = (r_state == ST_RUN);
   assign o_done = r_done;

endmodule : timer_channel

// File: rtl/timer_sched.sv
// timer_sched: shared-prescaler timer scheduler.
// A free-running prescaler divides clk_in into a one-cycle base tick that is
// shared by NUM_CH independent timer_channel instances. All outputs are flops.
// Optional feature: define TIMER_SCHED_PAUSE_EN to add a 'pause' input that
// freezes the prescaler (and therefore all countdowns) while high.
module timer_sched
   import timer_sched_pkg::*;
#(
   parameter int PRESCALE = PRESCALE_DEF,
   parameter int NUM_CH   = NUM_CH_DEF,
   parameter int CNT_W    = CNT_W_DEF
)(
   input  logic                    clk_in,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH*CNT_W-1:0] dur,
   input  logic [NUM_CH-1:0]       cancel,
`ifdef TIMER_SCHED_PAUSE_EN
   input  logic                    pause,
`endif
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       done,
   output logic                    tick
);

   localparam int               PRE_W    = $clog2(PRESCALE);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] r_pre_cnt;
   logic [PRE_W-1:0] w_pre_nxt;
   logic             r_tick;
   logic             w_tick_nxt;
   logic             w_hold;

`ifdef TIMER_SCHED_PAUSE_EN
   assign w_hold = pause;
`else
   assign w_hold = 1'b0;
`endif

   // Prescaler next count; tick is precomputed so it can come from a flop and
   // be high exactly while the count sits at PRESCALE-1. While held, the count
   // freezes and no new tick is produced; a count frozen at PRESCALE-1 has
   // already issued its tick and simply wraps to 0 on release.
   always_comb begin
      w_pre_nxt = r_pre_cnt;
      if (!w_hold) begin
         w_pre_nxt = (r_pre_cnt == PRE_LAST) ? '0 : (r_pre_cnt + 1'b1);
      end
      w_tick_nxt = (!w_hold) && (w_pre_nxt == PRE_LAST);
   end

   // Free-running prescaler and registered tick, never restarted by channels.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         r_pre_cnt <= '0;
         r_tick    <= 1'b0;
      end else begin
         r_pre_cnt <= w_pre_nxt;
         r_tick    <= w_tick_nxt;
      end
   end

   assign tick = r_tick;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      timer_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk_in   (clk_in),
         .rst      (rst),
         .i_tick   (r_tick),
         .i_start  (start[g]),
         .i_dur    (dur[g*CNT_W +: CNT_W]),
         .i_cancel (cancel[g]),
         .o_busy   (busy[g]),
         .o_done   (done[g])
      );
   end

endmodule : timer_sched

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed bench for timer_sched (PRESCALE=10, NUM_CH=4, CNT_W=8).
// A tick-count reference model is compared against the DUT every cycle, and
// literal hand-computed expectations pin key instants of each scenario.
// The pause scenario runs only when TIMER_SCHED_PAUSE_EN is defined.
module tb_timer_sched;

   localparam int P   = 10;
   localparam int NCH = 4;
   localparam int W   = 8;

   logic             clk_in = 1'b0;
   logic             rst;
   logic [NCH-1:0]   start;
   logic [NCH-1:0]   cancel;
   logic [NCH*W-1:0] dur;
   logic             pause;
   logic [NCH-1:0]   busy;
   logic [NCH-1:0]   done;
   logic             tick;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: tick happens when the number of unpaused edges since
   // reset release is P-1 mod P; each channel waits for a target global tick
   // count, and done shows in the cycle after that tick.
   int             m_edges;
   int             m_ticks;
   bit             m_act    [NCH];
   int             m_target [NCH];
   logic [NCH-1:0] m_done;

   timer_sched #(
      .PRESCALE (P),
      .NUM_CH   (NCH),
      .CNT_W    (W)
   ) dut (
      .clk_in (clk_in),
      .rst    (rst),
      .start  (start),
      .dur    (dur),
      .cancel (cancel),
`ifdef TIMER_SCHED_PAUSE_EN
      .pause  (pause),
`endif
      .busy   (busy),
      .done   (done),
      .tick   (tick)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic set_dur(input int ch, input int val);
      dur[ch*W +: W] = W'(val);
   endtask

   // Per-cycle compare against the model, then advance the model using this
   // cycle's inputs (which the DUT samples at the coming edge).
   always @(negedge clk_in) begin
      logic [NCH-1:0] busy_exp;
      bit             tk;
      if (!rst) begin
         chk("reset_tick", 32'(tick), 32'd0);
         chk("reset_busy", 32'(busy), 32'd0);
         chk("reset_done", 32'(done), 32'd0);
         m_edges = 0;
         m_ticks = 0;
         m_done  = '0;
         for (int ch = 0; ch < NCH; ch++) begin
            m_act[ch]    = 1'b0;
            m_target[ch] = 0;
         end
      end else begin
         tk = ((m_edges % P) == (P - 1));
         for (int ch = 0; ch < NCH; ch++) busy_exp[ch] = m_act[ch];
         chk("model_tick", 32'(tick), 32'(tk));
         chk("model_busy", 32'(busy), 32'(busy_exp));
         chk("model_done", 32'(done), 32'(m_done));
         if (tk) m_ticks++;
         m_done = '0;
         for (int ch = 0; ch < NCH; ch++) begin
            if (cancel[ch]) begin
               m_act[ch] = 1'b0;
            end else if (start[ch]) begin
               if (dur[ch*W +: W] == '0) begin
                  m_act[ch]  = 1'b0;
                  m_done[ch] = 1'b1;
               end else begin
                  m_act[ch]    = 1'b1;
                  m_target[ch] = m_ticks + int'(dur[ch*W +: W]);
               end
            end else if (m_act[ch] && tk && (m_ticks == m_target[ch])) begin
               m_act[ch]  = 1'b0;
               m_done[ch] = 1'b1;
            end
         end
         if (!pause) m_edges++;
      end
   end

   initial begin
      start  = '0;
      cancel = '0;
      dur    = '0;
      pause  = 1'b0;
      rst    = 1'b1;
      #1 rst = 1'b0;

      // 1. Reset held for 5 cycles, then released; ticks at edge 9, 19, ...
      wait_edges(5);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      rst = 1'b1;                         // edges counted E1, E2, ... from here
      wait_edges(8);                      // E8
      chk("tick_e8", 32'(tick), 32'd0);
      wait_edges(1);                      // E9
      chk("tick_first", 32'(tick), 32'd1);
      wait_edges(10);                     // E19
      chk("tick_second", 32'(tick), 32'd1);

      // 2. Basic countdown: dur=3 one cycle after a tick -> done after E50
      wait_edges(1);                      // E20
      start[0] = 1'b1;
      set_dur(0, 3);
      wait_edges(1);                      // E21
      start[0] = 1'b0;
      chk("basic_busy_rise", 32'(busy[0]), 32'd1);
      wait_edges(28);                     // E49
      chk("basic_done_early", 32'(done[0]), 32'd0);
      chk("basic_busy_hold", 32'(busy[0]), 32'd1);
      wait_edges(1);                      // E50
      chk("basic_done", 32'(done[0]), 32'd1);
      chk("basic_busy_fall", 32'(busy[0]), 32'd0);
      wait_edges(1);                      // E51
      chk("basic_done_once", 32'(done[0]), 32'd0);

      // 3a. Zero duration: immediate done, never busy
      start[1] = 1'b1;
      set_dur(1, 0);
      wait_edges(1);                      // E52
      start[1] = 1'b0;
      chk("zero_done", 32'(done[1]), 32'd1);
      chk("zero_busy", 32'(busy[1]), 32'd0);
      wait_edges(1);                      // E53
      chk("zero_done_once", 32'(done[1]), 32'd0);

      // 3b. dur=1 started in a tick cycle: that tick is not counted
      wait_edges(6);                      // E59 (tick cycle)
      chk("tick_e59", 32'(tick), 32'd1);
      start[2] = 1'b1;
      set_dur(2, 1);
      wait_edges(1);                      // E60
      start[2] = 1'b0;
      chk("tickstart_busy", 32'(busy[2]), 32'd1);
      wait_edges(9);                      // E69
      chk("tickstart_done_early", 32'(done[2]), 32'd0);
      wait_edges(1);                      // E70
      chk("tickstart_done", 32'(done[2]), 32'd1);
      chk("tickstart_busy_fall", 32'(busy[2]), 32'd0);

      // 4a. dur=5 on ch0, cancel after two ticks (E79, E89): no done ever
      start[0] = 1'b1;
      set_dur(0, 5);
      wait_edges(1);                      // E71
      start[0] = 1'b0;
      wait_edges(19);                     // E90
      chk("cancel_busy_before", 32'(busy[0]), 32'd1);
      cancel[0] = 1'b1;
      wait_edges(1);                      // E91
      cancel[0] = 1'b0;
      chk("cancel_busy", 32'(busy[0]), 32'd0);

      // 4b. dur=2, restarted after one tick with dur=4 -> done after E150
      wait_edges(9);                      // E100
      start[0] = 1'b1;
      set_dur(0, 2);
      wait_edges(1);                      // E101
      start[0] = 1'b0;
      wait_edges(9);                      // E110
      start[0] = 1'b1;
      set_dur(0, 4);
      wait_edges(1);                      // E111
      start[0] = 1'b0;
      wait_edges(9);                      // E120: old dur=2 run would end here
      chk("restart_no_old_done", 32'(done[0]), 32'd0);
      chk("restart_busy", 32'(busy[0]), 32'd1);
      wait_edges(29);                     // E149
      chk("restart_done_early", 32'(done[0]), 32'd0);
      wait_edges(1);                      // E150
      chk("restart_done", 32'(done[0]), 32'd1);

      // 4c. cancel and start together: cancel wins
      wait_edges(1);                      // E151
      start[0]  = 1'b1;
      cancel[0] = 1'b1;
      set_dur(0, 7);
      wait_edges(1);                      // E152
      start[0]  = 1'b0;
      cancel[0] = 1'b0;
      chk("cancel_start_busy", 32'(busy[0]), 32'd0);

      // 5a. All four channels dur=2 together -> all done after E170
      start = '1;
      for (int ch = 0; ch < NCH; ch++) set_dur(ch, 2);
      wait_edges(1);                      // E153
      start = '0;
      wait_edges(17);                     // E170
      chk("simul_done", 32'(done), 32'hF);
      chk("simul_busy", 32'(busy), 32'h0);

      // 5b. Async reset mid-run clears busy at once, no done
      start = '1;
      for (int ch = 0; ch < NCH; ch++) set_dur(ch, 5);
      wait_edges(1);                      // E171
      start = '0;
      wait_edges(5);                      // E176
      chk("midrun_busy", 32'(busy), 32'hF);
      #2 rst = 1'b0;
      #1;
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_done", 32'(done), 32'd0);
      wait_edges(3);
      rst = 1'b1;                         // new release: R0
      wait_edges(9);                      // R9
      chk("rerelease_tick", 32'(tick), 32'd1);

`ifdef TIMER_SCHED_PAUSE_EN
      // 6. dur=3, pause 25 cycles after first tick -> done at R65 (R40 + 25)
      wait_edges(1);                      // R10
      start[0] = 1'b1;
      set_dur(0, 3);
      wait_edges(1);                      // R11
      start[0] = 1'b0;
      wait_edges(9);                      // R20
      pause = 1'b1;
      wait_edges(9);                      // R29: would be a tick if unpaused
      chk("pause_no_tick", 32'(tick), 32'd0);
      chk("pause_busy", 32'(busy[0]), 32'd1);
      wait_edges(16);                     // R45: pause sampled high at R21..R45
      pause = 1'b0;
      wait_edges(19);                     // R64
      chk("pause_done_early", 32'(done[0]), 32'd0);
      wait_edges(1);                      // R65
      chk("pause_done", 32'(done[0]), 32'd1);
`endif

      wait_edges(5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_timer_sched
